mmu_axi_rd_arbiter: RTL

Arbitrates the single AXI read-address/read-data channel between the instruction MMU requester (master 0) and the data MMU requester (master 1). It latches the winning request, drives AR until accepted, and routes R beats to the owner until `rlast`. Only one read transaction is outstanding at a time. It sits between the inst/data MMU controllers and the AXI master port, replacing combinational read-channel muxing with a grant that cannot change mid-burst.

---
 rtl/mmu_pkg.sv | 22 ++
 rtl/mmu_arb_pick.sv | 34 +++
 rtl/mmu_axi_rd_arbiter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/mmu_pkg.sv
// mmu_pkg: shared types and constants for the MMU AXI read arbiter.
//   arb_state_t  : arbiter FSM states (IDLE / ADDR / DATA)
//   MST_INST/DATA: master index, also used as the AXI arid value
//   BURST_*      : AXI arburst encodings used by the arbiter
//   LINE_LEN     : arlen of a cache-line fill (16 beats)
//   WORD_SIZE    : arsize of a line-fill beat (4 bytes)
package mmu_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_t;

    localparam logic       MST_INST    = 1'b0;
    localparam logic       MST_DATA    = 1'b1;
    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [7:0] LINE_LEN    = 8'd15;
    localparam logic [2:0] WORD_SIZE   = 3'b010;

endpackage

// File: rtl/mmu_arb_pick.sv
// mmu_arb_pick: combinational two-way grant between the inst and data
// requesters.
//   i_req_inst, i_req_data : pending requests
//   i_last_grant           : master granted on the previous IDLE exit
//   o_valid                : at least one request pending
//   o_grant                : winning master (MST_INST / MST_DATA)
// Macro MMU_ARB_ROUND_ROBIN_EN: when both request, the master not granted
// last wins. Without it, data always beats inst and i_last_grant is ignored.
module mmu_arb_pick
    import mmu_pkg::*;
(
    input  logic i_req_inst,
    input  logic i_req_data,
    input  logic i_last_grant,
    output logic o_valid,
    output logic o_grant
);

    assign o_valid = i_req_inst | i_req_data;

`ifdef MMU_ARB_ROUND_ROBIN_EN
    always_comb begin
        o_grant = i_req_data ? MST_DATA : MST_INST;
        if (i_req_inst && i_req_data) begin
            o_grant = (i_last_grant == MST_INST) ? MST_DATA : MST_INST;
        end
    end
`else
    logic w_unused_last;
    assign w_unused_last = i_last_grant;
    assign o_grant       = i_req_data ? MST_DATA : MST_INST;
`endif

endmodule

// File: rtl/mmu_axi_rd_arbiter.sv
// mmu_axi_rd_arbiter: shares one AXI read channel between the instruction
// MMU (master 0) and the data MMU (master 1). One transaction outstanding.
//   clk, rst (async, active-low)
//   i_req_* / d_req_* : requests (held until *_req_ok pulses)
//   i_r* / d_r*       : R beats routed to the owner, zero otherwise
//   ar*, arready      : AXI AR channel (arid 0 = inst, 1 = data)
//   r*, rready        : AXI R channel
//   o_dbg_state       : current FSM state (arb_state_t encoding)
// Macro MMU_ARB_ROUND_ROBIN_EN selects round-robin arbitration and builds
// the last-grant register; default is fixed data-over-inst priority.
//
// Handshake: AR transfers on arvalid && arready; arvalid and the ar* fields
// are held stable from IDLE exit until that cycle. R transfers on
// rvalid && rready; rready is high only in DATA. rid is not used for
// routing; a mismatch against arid is reported as an error.
module mmu_axi_rd_arbiter
    import mmu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req_en,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic              i_req_single,
    input  logic [2:0]        i_req_size,
    output logic              i_req_ok,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_rvalid,
    output logic              i_rlast,
    output logic              i_rerr,
    input  logic              d_req_en,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic              d_req_single,
    input  logic [2:0]        d_req_size,
    output logic              d_req_ok,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_rvalid,
    output logic              d_rlast,
    output logic              d_rerr,
    output logic [3:0]        arid,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic              arvalid,
    input  logic              arready,
    input  logic [3:0]        rid,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,
    output logic [1:0]        o_dbg_state
);

    arb_state_t        r_state;
    logic              r_grant;
    logic              r_err;
    logic [3:0]        r_arid;
    logic [ADDR_W-1:0] r_araddr;
    logic [7:0]        r_arlen;
    logic [2:0]        r_arsize;
    logic [1:0]        r_arburst;

    logic              w_last_grant;
    logic              w_pick_valid;
    logic              w_pick_grant;
    logic              w_sel_single;
    logic [2:0]        w_sel_size;
    logic              w_own_i;
    logic              w_own_d;
    logic              w_beat_err;

`ifdef MMU_ARB_ROUND_ROBIN_EN
    logic r_last_grant;
    assign w_last_grant = r_last_grant;
`else
    assign w_last_grant = MST_INST;
`endif

    mmu_arb_pick u_pick (
        .i_req_inst   (i_req_en),
        .i_req_data   (d_req_en),
        .i_last_grant (w_last_grant),
        .o_valid      (w_pick_valid),
        .o_grant      (w_pick_grant)
    );

    assign w_sel_single = (w_pick_grant == MST_DATA) ? d_req_single : i_req_single;
    assign w_sel_size   = (w_pick_grant == MST_DATA) ? d_req_size   : i_req_size;

    // Any bad response or a beat tagged with a foreign id poisons the burst.
    assign w_beat_err = (rresp != 2'b00) || (rid != r_arid);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ARB_IDLE;
            r_grant   <= MST_INST;
            r_err     <= 1'b0;
            r_arid    <= '0;
            r_araddr  <= '0;
            r_arlen   <= '0;
            r_arsize  <= '0;
            r_arburst <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_pick_valid) begin
                        r_grant   <= w_pick_grant;
                        r_arid    <= {3'b000, w_pick_grant};
                        r_araddr  <= (w_pick_grant == MST_DATA) ? d_req_addr : i_req_addr;
                        r_arlen   <= w_sel_single ? 8'd0 : LINE_LEN;
                        r_arsize  <= w_sel_single ? w_sel_size : WORD_SIZE;
                        r_arburst <= w_sel_single ? BURST_FIXED : BURST_INCR;
                        r_err     <= 1'b0;
                        r_state   <= ARB_ADDR;
                    end
                end
                ARB_ADDR: begin
                    if (arready) begin
                        r_state <= ARB_DATA;
                    end
                end
                ARB_DATA: begin
                    if (rvalid) begin
                        if (rlast) begin
                            r_err   <= 1'b0;
                            r_state <= ARB_IDLE;
                        end else if (w_beat_err) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

`ifdef MMU_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_grant <= MST_INST;
        end else if (r_state == ARB_IDLE && w_pick_valid) begin
            r_last_grant <= w_pick_grant;
        end
    end
`endif

    assign arvalid     = (r_state == ARB_ADDR);
    assign rready      = (r_state == ARB_DATA);
    assign arid        = r_arid;
    assign araddr      = r_araddr;
    assign arlen       = r_arlen;
    assign arsize      = r_arsize;
    assign arburst     = r_arburst;
    assign o_dbg_state = r_state;

    assign i_req_ok = arvalid && arready && (r_grant == MST_INST);
    assign d_req_ok = arvalid && arready && (r_grant == MST_DATA);

    assign w_own_i = rready && (r_grant == MST_INST);
    assign w_own_d = rready && (r_grant == MST_DATA);

    assign i_rdata  = w_own_i ? rdata : '0;
    assign d_rdata  = w_own_d ? rdata : '0;
    assign i_rvalid = w_own_i && rvalid;
    assign d_rvalid = w_own_d && rvalid;
    assign i_rlast  = i_rvalid && rlast;
    assign d_rlast  = d_rvalid && rlast;
    // Error covers earlier beats (r_err) plus the last beat itself.
    assign i_rerr   = i_rlast && (r_err || w_beat_err);
    assign d_rerr   = d_rlast && (r_err || w_beat_err);

endmodule
